// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the AXI4-Stream pipeline slices.
//   ST_EMPTY / ST_BUSY / ST_FULL : 2-bit occupancy state of a two-entry slice.
//                                  The encoding equals the number of held beats,
//                                  so it can be exported directly as occupancy.
// -----------------------------------------------------------------------------
package stream_pkg;

    typedef logic [1:0] slice_state_t;

    localparam slice_state_t ST_EMPTY = 2'd0;
    localparam slice_state_t ST_BUSY  = 2'd1;
    localparam slice_state_t ST_FULL  = 2'd2;

endpackage : stream_pkg

// File: rtl/input_skid_buffer.sv
// -----------------------------------------------------------------------------
// input_skid_buffer
// Two-entry AXI4-Stream skid buffer. Both the forward path (out_data/out_valid)
// and the backward path (in_ready) come straight from flops, so no
// combinational path exists between any input and any output port.
//
// Ports
//   aclk       in   clock, rising edge
//   aresetn    in   synchronous active-low reset
//   in_data    in   upstream payload
//   in_valid   in   upstream beat valid
//   in_ready   out  registered; beat accepted when in_valid & in_ready
//   out_data   out  registered payload (main register)
//   out_valid  out  registered; main register holds a beat
//   out_ready  in   downstream accept
//   occupancy  out  number of held beats (0, 1 or 2)
// -----------------------------------------------------------------------------
module input_skid_buffer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            occupancy
);

    slice_state_t          state_r;
    slice_state_t          next_state_s;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] main_r;
    logic [DATA_WIDTH-1:0] skid_r;

    logic                  acc_s;
    logic                  pop_s;
    logic                  load_main_s;
    logic                  main_from_skid_s;
    logic                  load_skid_s;

    // Handshake qualifiers, built only from registered outputs and port inputs.
    always_comb begin
        acc_s = in_valid  & in_ready_r;
        pop_s = out_valid_r & out_ready;
    end

    // Next-state decode and data-register load enables.
    always_comb begin
        next_state_s     = state_r;
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (acc_s) begin
                    load_main_s  = 1'b1;
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (acc_s && !pop_s) begin
                    // Downstream stalled while we were still advertising ready:
                    // park the new beat behind the one already on the output.
                    load_skid_s  = 1'b1;
                    next_state_s = ST_FULL;
                end else if (!acc_s && pop_s) begin
                    next_state_s = ST_EMPTY;
                end else if (acc_s && pop_s) begin
                    // Old beat leaves this edge, so the new one takes its place.
                    load_main_s  = 1'b1;
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop_s) begin
                    load_main_s      = 1'b1;
                    main_from_skid_s = 1'b1;
                    next_state_s     = ST_BUSY;
                end else begin
                    next_state_s = ST_FULL;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean empty slice.
                next_state_s = ST_EMPTY;
            end
        endcase
    end

    // Control registers; ready/valid are derived from the next state so they
    // leave the flops already aligned with the state they describe.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != ST_FULL);
            out_valid_r <= (next_state_s != ST_EMPTY);
        end
    end

    // Payload registers; contents are don't-care while out_valid is low, so no reset.
    always_ff @(posedge aclk) begin
        if (load_main_s) begin
            main_r <= main_from_skid_s ? skid_r : in_data;
        end
        if (load_skid_s) begin
            skid_r <= in_data;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = state_r;

endmodule : input_skid_buffer
